// File: rtl/singcyc_periph_pkg.sv
// Shared register offsets, TCON bit positions and types for the single-cycle
// core's memory-mapped peripheral block.
package singcyc_periph_pkg;

  localparam logic [7:0] PERIPH_OFF_TH      = 8'h00;
  localparam logic [7:0] PERIPH_OFF_TL      = 8'h04;
  localparam logic [7:0] PERIPH_OFF_TCON    = 8'h08;
  localparam logic [7:0] PERIPH_OFF_LED     = 8'h0C;
  localparam logic [7:0] PERIPH_OFF_SW      = 8'h10;
  localparam logic [7:0] PERIPH_OFF_DIGITS  = 8'h14;
  localparam logic [7:0] PERIPH_OFF_SYSTICK = 8'h18;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  // Packed so that st/ie/en land on TCON_ST/TCON_IE/TCON_EN.
  typedef struct packed {
    logic st;
    logic ie;
    logic en;
  } tcon_t;

  // Word-aligned offset within the 256-byte window.
  function automatic logic [7:0] word_offset(input logic [31:0] addr);
    return {addr[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/singcyc_periph_if.sv
// Data-memory port between the core (master) and the peripheral block (slave).
// The core drives address/strobes/write data; the slave answers combinationally
// in the same cycle with read data and a window-hit flag, no handshake stalls.
interface singcyc_periph_if;
  logic [31:0] iAddr;
  logic        iMemRead;
  logic        iMemWrite;
  logic [31:0] iWrData;
  logic [31:0] oRdData;
  logic        oHit;

  modport master (
    output iAddr, iMemRead, iMemWrite, iWrData,
    input  oRdData, oHit
  );

  modport slave (
    input  iAddr, iMemRead, iMemWrite, iWrData,
    output oRdData, oHit
  );
endinterface

// File: rtl/singcyc_timer.sv
// Reloading 32-bit up-counter: TH reload, TL count, TCON control/status and
// a level interrupt raised on overflow.
module singcyc_timer
  import singcyc_periph_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_th_i,
  input  logic        wr_tl_i,
  input  logic        wr_tcon_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output tcon_t       tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  tcon_t       tcon_q, tcon_d;
  logic        ovf;
  logic        ovf_set;

  assign ovf     = tcon_q.en && (tl_q == 32'hFFFF_FFFF);
  assign ovf_set = ovf && tcon_q.ie;

  // Core writes override the counter; reload always uses the pre-write TH.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (wr_th_i) th_d = wdata_i;
    if (wr_tl_i)          tl_d = wdata_i;
    else if (ovf)         tl_d = th_q;
    else if (tcon_q.en)   tl_d = tl_q + 32'd1;
    if (wr_tcon_i) begin
      tcon_d.en = wdata_i[TCON_EN];
      tcon_d.ie = wdata_i[TCON_IE];
      tcon_d.st = wdata_i[TCON_ST] | ovf_set;
    end else begin
      tcon_d.st = tcon_q.st | ovf_set;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q.ie & tcon_q.st;

endmodule

// File: rtl/singcyc_periph.sv
// Peripheral responder for a 256-byte window: decode, LED/DIGITS/SW/SYSTICK
// registers, the timer sub-block and a zero-latency read mux.
module singcyc_periph
  import singcyc_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  singcyc_periph_if.slave   bus,
  input  logic [SW_W-1:0]   iSwitch,
  output logic [LED_W-1:0]  oLed,
  output logic [11:0]       oDigits,
  output logic              oIrq
);

  logic              hit;
  logic              wr;
  logic [7:0]        off;
  logic [LED_W-1:0]  led_q, led_d;
  logic [11:0]       digits_q, digits_d;
  logic [31:0]       systick_q;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  logic [31:0]       th, tl;
  tcon_t             tcon;
  logic              unused_addr_lsb;

  assign hit             = (bus.iAddr[31:8] == BASE_ADDR[31:8]);
  assign wr              = bus.iMemWrite && hit;
  assign off             = word_offset(bus.iAddr);
  assign unused_addr_lsb = ^bus.iAddr[1:0];

  singcyc_timer u_timer (
    .clk_i     (iClk),
    .rst_i     (iRst),
    .wr_th_i   (wr && (off == PERIPH_OFF_TH)),
    .wr_tl_i   (wr && (off == PERIPH_OFF_TL)),
    .wr_tcon_i (wr && (off == PERIPH_OFF_TCON)),
    .wdata_i   (bus.iWrData),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (oIrq)
  );

  always_comb begin
    led_d    = led_q;
    digits_d = digits_q;
    if (wr && (off == PERIPH_OFF_LED))    led_d    = bus.iWrData[LED_W-1:0];
    if (wr && (off == PERIPH_OFF_DIGITS)) digits_d = bus.iWrData[11:0];
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      led_q     <= '0;
      digits_q  <= '0;
      systick_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      digits_q  <= digits_d;
      systick_q <= systick_q + 32'd1;
      sw_meta_q <= iSwitch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Register state before any same-cycle write, so read+write shows old data.
  always_comb begin
    bus.oRdData = 32'h0;
    if (bus.iMemRead && hit) begin
      case (off)
        PERIPH_OFF_TH:      bus.oRdData = th;
        PERIPH_OFF_TL:      bus.oRdData = tl;
        PERIPH_OFF_TCON:    bus.oRdData = {29'h0, tcon};
        PERIPH_OFF_LED:     bus.oRdData = 32'(led_q);
        PERIPH_OFF_SW:      bus.oRdData = 32'(sw_sync_q);
        PERIPH_OFF_DIGITS:  bus.oRdData = {20'h0, digits_q};
        PERIPH_OFF_SYSTICK: bus.oRdData = systick_q;
        default:            bus.oRdData = 32'h0;
      endcase
    end
  end

  assign bus.oHit = hit;
  assign oLed     = led_q;
  assign oDigits  = digits_q;

endmodule

// File: tb/tb_singcyc_periph.sv
// Self-checking bench for singcyc_periph: register map, timer overflow and
// write races, switch synchroniser, systick and asynchronous reset.
module tb_singcyc_periph;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sw  = 8'h00;
  logic [7:0]  led;
  logic [11:0] digits;
  logic        irq;
  logic [31:0] cyc;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  singcyc_periph_if bus ();

  singcyc_periph #(.BASE_ADDR(B), .LED_W(8), .SW_W(8)) dut (
    .iClk    (clk),
    .iRst    (rst),
    .bus     (bus),
    .iSwitch (sw),
    .oLed    (led),
    .oDigits (digits),
    .oIrq    (irq)
  );

  // clock / reset block
  always #10 clk = ~clk;

  // reference cycle count since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 32'h0;
    else     cyc <= cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus.iAddr    = addr;
    bus.iMemRead = 1'b1;
    #1;
    check(tag, bus.oRdData, exp_q.pop_front());
    bus.iMemRead = 1'b0;
  endtask

  task automatic hit_chk(input string tag, input logic [31:0] addr, input logic exp);
    bus.iAddr = addr;
    #1;
    check(tag, {31'h0, bus.oHit}, {31'h0, exp});
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.iAddr     = addr;
    bus.iWrData   = data;
    bus.iMemWrite = 1'b1;
    @(negedge clk);
    bus.iMemWrite = 1'b0;
  endtask

  initial begin
    bus.iAddr     = 32'h0;
    bus.iMemRead  = 1'b0;
    bus.iMemWrite = 1'b0;
    bus.iWrData   = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset values
    rd("rst_th",   B + 32'h00, 32'h0);
    rd("rst_tl",   B + 32'h04, 32'h0);
    rd("rst_tcon", B + 32'h08, 32'h0);
    rd("rst_led",  B + 32'h0C, 32'h0);
    @(negedge clk);
    rd("rst_sw",     B + 32'h10, 32'h0);
    rd("rst_digits", B + 32'h14, 32'h0);
    rd("rst_unmap",  B + 32'h20, 32'h0);
    hit_chk("hit_unmap", B + 32'h20, 1'b1);
    @(negedge clk);
    rd("miss_rd", 32'h1000_0000, 32'h0);
    hit_chk("miss_hit", 32'h1000_0000, 1'b0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    rd("systick", B + 32'h18, cyc);
    bus.iAddr = B + 32'h0C;
    #1 check("rd_gated", bus.oRdData, 32'h0);

    // timer overflow and reload
    wr(B + 32'h00, 32'hFFFF_FFF0);
    wr(B + 32'h04, 32'hFFFF_FFFE);
    wr(B + 32'h08, 32'h3);
    rd("tl_start", B + 32'h04, 32'hFFFF_FFFE);
    @(negedge clk);
    rd("tl_max",    B + 32'h04, 32'hFFFF_FFFF);
    rd("tcon_pre",  B + 32'h08, 32'h3);
    check("irq_pre", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rd("tl_reload", B + 32'h04, 32'hFFFF_FFF0);
    rd("tcon_ovf",  B + 32'h08, 32'h7);
    check("irq_ovf", {31'h0, irq}, 32'h1);
    @(negedge clk);
    rd("tl_cont", B + 32'h04, 32'hFFFF_FFF1);
    repeat (14) @(negedge clk);
    rd("tl_max2", B + 32'h04, 32'hFFFF_FFFF);
    wr(B + 32'h08, 32'h3);
    rd("tl_reload2",   B + 32'h04, 32'hFFFF_FFF0);
    rd("tcon_ovf_win", B + 32'h08, 32'h7);
    check("irq_ovf_win", {31'h0, irq}, 32'h1);
    wr(B + 32'h08, 32'h3);
    rd("tcon_clr", B + 32'h08, 32'h3);
    check("irq_clr", {31'h0, irq}, 32'h0);
    rd("tl_after_clr", B + 32'h04, 32'hFFFF_FFF1);

    // TL write vs increment
    wr(B + 32'h04, 32'h5);
    rd("tl_wr_wins", B + 32'h04, 32'h5);
    @(negedge clk);
    rd("tl_inc", B + 32'h04, 32'h6);

    // simultaneous read and write shows pre-write data
    bus.iAddr     = B + 32'h00;
    bus.iWrData   = 32'h0000_1234;
    bus.iMemRead  = 1'b1;
    bus.iMemWrite = 1'b1;
    #1 check("rdwr_old", bus.oRdData, 32'hFFFF_FFF0);
    @(negedge clk);
    bus.iMemRead  = 1'b0;
    bus.iMemWrite = 1'b0;
    rd("rdwr_new", B + 32'h00, 32'h0000_1234);

    // LED / DIGITS narrow registers, RO offsets
    wr(B + 32'h0C, 32'hABCD_12A5);
    check("led_port", {24'h0, led}, 32'hA5);
    rd("led_rd", B + 32'h0C, 32'hA5);
    wr(B + 32'h16, 32'hFFFF_FABC);
    check("digits_port", {20'h0, digits}, 32'hABC);
    rd("digits_rd", B + 32'h14, 32'hABC);
    wr(B + 32'h10, 32'hFFFF_FFFF);
    rd("sw_ro", B + 32'h10, 32'h0);
    wr(B + 32'h18, 32'h0);
    rd("systick_ro", B + 32'h18, cyc);

    // switch synchroniser latency
    sw = 8'h3C;
    rd("sw_now", B + 32'h10, 32'h0);
    @(negedge clk);
    rd("sw_1edge", B + 32'h10, 32'h0);
    @(negedge clk);
    rd("sw_2edge", B + 32'h10, 32'h3C);

    // asynchronous reset mid-count with interrupt pending
    wr(B + 32'h04, 32'hFFFF_FFFF);
    @(negedge clk);
    check("irq_before_rst", {31'h0, irq}, 32'h1);
    #3 rst = 1'b1;
    #1;
    rd("arst_tl",   B + 32'h04, 32'h0);
    rd("arst_tcon", B + 32'h08, 32'h0);
    rd("arst_sys",  B + 32'h18, 32'h0);
    check("arst_irq",    {31'h0, irq},    32'h0);
    check("arst_led",    {24'h0, led},    32'h0);
    check("arst_digits", {20'h0, digits}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd("post_rst_tl", B + 32'h04, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
